// File: rtl/uart_pkg.sv
// uart_pkg: encodings and constants shared by the UART RX/TX parity logic.
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'd0,
    PAR_ODD   = 2'd1,
    PAR_MARK  = 2'd2,
    PAR_SPACE = 2'd3
  } par_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } par_chk_state_t;

  localparam int MIN_DATA_LEN = 5;

endpackage

`default_nettype wire

// File: rtl/uart_parity_accum.sv
// uart_parity_accum: serial XOR accumulator plus mode-to-parity-bit mux.
`default_nettype none

module uart_parity_accum
  import uart_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      clr,
  input  logic      en,
  input  logic      bit_in,
  input  par_mode_t mode,
  output logic      acc,
  output logic      par
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= 1'b0;
    end else if (clr) begin
      acc <= 1'b0;
    end else if (en) begin
      acc <= acc ^ bit_in;
    end
  end

  always_comb begin
    par = 1'b0;
    case (mode)
      PAR_EVEN:  par = acc;
      PAR_ODD:   par = ~acc;
      PAR_MARK:  par = 1'b1;
      PAR_SPACE: par = 1'b0;
      default:   par = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/uart_parity_check.sv
// uart_parity_check: serial data assembly and parity check for one RX frame.
`default_nettype none

module uart_parity_check
  import uart_pkg::*;
#(
  parameter int MAX_WIDTH = 9,
  parameter int LEN_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     data_len,
  input  logic                 par_en,
  input  logic [1:0]           par_mode,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  input  logic                 abort,
  output logic                 busy,
  output logic [MAX_WIDTH-1:0] data_out,
  output logic                 exp_parity,
  output logic                 par_err,
  output logic                 done
);

  par_chk_state_t       state;
  logic [LEN_W-1:0]     cnt;
  logic [LEN_W-1:0]     len_q;
  logic                 par_en_q;
  par_mode_t            mode_q;
  logic [LEN_W-1:0]     len_clamped;
  logic [MAX_WIDTH-1:0] bit_word;
  logic                 last_bit;
  logic                 acc_clr;
  logic                 acc_en;
  logic                 acc;
  logic                 par;

  always_comb begin
    len_clamped = data_len;
    if (data_len < LEN_W'(MIN_DATA_LEN)) begin
      len_clamped = LEN_W'(MIN_DATA_LEN);
    end else if (data_len > LEN_W'(MAX_WIDTH)) begin
      len_clamped = LEN_W'(MAX_WIDTH);
    end
  end

  // data_out is cleared at start, so OR-ing the shifted bit writes position cnt
  assign bit_word = MAX_WIDTH'(bit_in) << cnt;
  assign last_bit = (cnt == len_q - LEN_W'(1));
  assign acc_clr  = abort | start;
  assign acc_en   = (state == ST_DATA) & bit_valid & ~abort & ~start;

  uart_parity_accum u_accum (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr),
    .en     (acc_en),
    .bit_in (bit_in),
    .mode   (mode_q),
    .acc    (acc),
    .par    (par)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      len_q      <= LEN_W'(MIN_DATA_LEN);
      par_en_q   <= 1'b0;
      mode_q     <= PAR_EVEN;
      data_out   <= '0;
      exp_parity <= 1'b0;
      par_err    <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done       <= 1'b0;
      par_err    <= 1'b0;
      exp_parity <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else if (start) begin
        state    <= ST_DATA;
        cnt      <= '0;
        data_out <= '0;
        len_q    <= len_clamped;
        par_en_q <= par_en;
        mode_q   <= par_mode_t'(par_mode);
        busy     <= 1'b1;
      end else begin
        case (state)
          ST_DATA: begin
            if (bit_valid) begin
              data_out <= data_out | bit_word;
              cnt      <= cnt + LEN_W'(1);
              if (last_bit) begin
                if (par_en_q) begin
                  state <= ST_PARITY;
                end else begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                end
              end
            end
          end
          ST_PARITY: begin
            if (bit_valid) begin
              state      <= ST_DONE;
              done       <= 1'b1;
              exp_parity <= par;
              par_err    <= bit_in ^ par;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_parity_check.sv
// tb_uart_parity_check: table-driven frames with a done-time scoreboard.
`default_nettype none

module tb_uart_parity_check;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] data_len;
  logic       par_en;
  logic [1:0] par_mode;
  logic       bit_valid;
  logic       bit_in;
  logic       abort;
  logic       busy;
  logic [8:0] data_out;
  logic       exp_parity;
  logic       par_err;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] len;
    logic       en;
    logic [1:0] mode;
    logic [8:0] data;
    logic       pbit;
    logic [8:0] exp_data;
    logic       exp_par;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [8:0] d;
    logic       p;
    logic       e;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];

  uart_parity_check #(.MAX_WIDTH(9), .LEN_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data_len   (data_len),
    .par_en     (par_en),
    .par_mode   (par_mode),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .abort      (abort),
    .busy       (busy),
    .data_out   (data_out),
    .exp_parity (exp_parity),
    .par_err    (par_err),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // scoreboard: every done pulse must match the oldest outstanding frame
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_data_out", data_out, e.d);
        check("sb_exp_parity", {8'd0, exp_parity}, {8'd0, e.p});
        check("sb_par_err", {8'd0, par_err}, {8'd0, e.e});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff_len(input logic [3:0] l);
    if (l < 4'd5) return 5;
    if (l > 4'd9) return 9;
    return int'(l);
  endfunction

  task automatic do_start(input logic [3:0] l, input logic en, input logic [1:0] m,
                          input logic with_bit);
    start     = 1'b1;
    data_len  = l;
    par_en    = en;
    par_mode  = m;
    bit_valid = with_bit;
    bit_in    = 1'b1;
    step();
    start     = 1'b0;
    bit_valid = 1'b0;
    data_len  = 4'd0;
    par_mode  = 2'd3;
    par_en    = ~en;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    step();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic send_body(input vec_t v);
    for (int i = 0; i < eff_len(v.len); i++) send_bit(v.data[i]);
    if (v.en) send_bit(v.pbit);
    check("done_latency", {8'd0, done}, 9'd1);
    check("busy_in_done", {8'd0, busy}, 9'd1);
  endtask

  task automatic run_frame(input vec_t v);
    exp_t e;
    e.d = v.exp_data;
    e.p = v.exp_par;
    e.e = v.exp_err;
    sb.push_back(e);
    do_start(v.len, v.en, v.mode, 1'b0);
    check("busy_after_start", {8'd0, busy}, 9'd1);
    send_body(v);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{4'd8,  1'b1, 2'd0, 9'h0A5, 1'b0, 9'h0A5, 1'b0, 1'b0};
    vecs[1] = '{4'd7,  1'b1, 2'd1, 9'h041, 1'b1, 9'h041, 1'b1, 1'b0};
    vecs[2] = '{4'd7,  1'b1, 2'd1, 9'h041, 1'b0, 9'h041, 1'b1, 1'b1};
    vecs[3] = '{4'd9,  1'b1, 2'd2, 9'h1FF, 1'b0, 9'h1FF, 1'b1, 1'b1};
    vecs[4] = '{4'd9,  1'b1, 2'd3, 9'h1FF, 1'b0, 9'h1FF, 1'b0, 1'b0};
    vecs[5] = '{4'd5,  1'b0, 2'd1, 9'h015, 1'b0, 9'h015, 1'b0, 1'b0};
    vecs[6] = '{4'd2,  1'b0, 2'd1, 9'h015, 1'b0, 9'h015, 1'b0, 1'b0};
    vecs[7] = '{4'd15, 1'b1, 2'd0, 9'h155, 1'b1, 9'h155, 1'b1, 1'b0};
    vecs[8] = '{4'd6,  1'b1, 2'd0, 9'h02B, 1'b1, 9'h02B, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; data_len = 4'd0; par_en = 1'b0; par_mode = 2'd0;
    bit_valid = 1'b0; bit_in = 1'b0; abort = 1'b0;
    step(); step();
    check("rst_busy", {8'd0, busy}, 9'd0);
    check("rst_data_out", data_out, 9'd0);
    check("rst_done", {8'd0, done}, 9'd0);
    check("rst_par_err", {8'd0, par_err}, 9'd0);
    check("rst_exp_parity", {8'd0, exp_parity}, 9'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      run_frame(vecs[i]);
      step();
      check("busy_idle_after", {8'd0, busy}, 9'd0);
      step();
    end

    // back-to-back: second start lands in the DONE cycle of the first
    run_frame(vecs[0]);
    run_frame(vecs[2]);
    step(); step();

    // abort after three bits: partial word held, no done
    do_start(4'd8, 1'b1, 2'd0, 1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", {8'd0, busy}, 9'd0);
    check("abort_data_held", data_out, 9'h003);
    for (int i = 0; i < 12; i++) send_bit(1'b1);
    check("abort_stays_idle", {8'd0, busy}, 9'd0);
    step();

    // start coincident with bit_valid mid-frame discards the bit and restarts
    do_start(4'd8, 1'b1, 2'd1, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    v = '{4'd8, 1'b1, 2'd0, 9'h03C, 1'b0, 9'h03C, 1'b0, 1'b0};
    sb.push_back('{9'h03C, 1'b0, 1'b0});
    do_start(4'd8, 1'b1, 2'd0, 1'b1);
    send_body(v);
    step(); step();

    // asynchronous reset while waiting for the parity bit
    v = vecs[0];
    sb.push_back('{9'h0A5, 1'b0, 1'b0});
    do_start(v.len, v.en, v.mode, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(v.data[i]);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_busy", {8'd0, busy}, 9'd0);
    check("arst_data_out", data_out, 9'd0);
    check("arst_done", {8'd0, done}, 9'd0);
    sb.delete();
    step();
    rst = 1'b0;
    step();
    send_bit(1'b0);
    check("arst_no_resume", {8'd0, busy}, 9'd0);
    run_frame(vecs[1]);
    step(); step(); step();

    check("sb_drained", 9'(sb.size()), 9'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
